// File: rtl/wide_mux_unit.sv
// Wide 2:1 and 4:1 datapath selectors with combinational outputs and
// registered copies for pipeline-stage use.
module wide_mux_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in2 [0:1],
  input  logic             sel2,
  output logic [WIDTH-1:0] out2,
  input  logic [WIDTH-1:0] in4 [0:3],
  input  logic [1:0]       sel4,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out2_q,
  output logic [WIDTH-1:0] out4_q
);

  // Per-bit gate tree: inverter on the select, two ANDs and an OR per bit.
  function automatic logic [WIDTH-1:0] mux2_1_wide(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             s
  );
    logic [WIDTH-1:0] s_v;
    s_v = {WIDTH{s}};
    return (a & ~s_v) | (b & s_v);
  endfunction

  // sel[0] resolves within each pair, sel[1] picks between the pairs.
  function automatic logic [WIDTH-1:0] mux4_1_wide(
    input logic [WIDTH-1:0] a0,
    input logic [WIDTH-1:0] a1,
    input logic [WIDTH-1:0] a2,
    input logic [WIDTH-1:0] a3,
    input logic [1:0]       s
  );
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    lo = mux2_1_wide(a0, a1, s[0]);
    hi = mux2_1_wide(a2, a3, s[0]);
    return mux2_1_wide(lo, hi, s[1]);
  endfunction

  logic [WIDTH-1:0] out2_d;
  logic [WIDTH-1:0] out4_d;

  always_comb begin
    out2_d = mux2_1_wide(in2[0], in2[1], sel2);
    out4_d = mux4_1_wide(in4[0], in4[1], in4[2], in4[3], sel4);
  end

  assign out2 = out2_d;
  assign out4 = out4_d;

  // Pipeline copy: one cycle behind the combinational results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out2_q <= '0;
      out4_q <= '0;
    end else begin
      out2_q <= out2_d;
      out4_q <= out4_d;
    end
  end

endmodule

// File: tb/tb_wide_mux_unit.sv
// Directed self-checking bench for wide_mux_unit (64-bit and 16-bit instances).
module tb_wide_mux_unit;

  logic        clk;
  logic        reset;
  logic [63:0] in2 [0:1];
  logic        sel2;
  logic [63:0] out2;
  logic [63:0] in4 [0:3];
  logic [1:0]  sel4;
  logic [63:0] out4;
  logic [63:0] out2_q;
  logic [63:0] out4_q;

  logic [15:0] in2_s [0:1];
  logic        sel2_s;
  logic [15:0] out2_s;
  logic [15:0] in4_s [0:3];
  logic [1:0]  sel4_s;
  logic [15:0] out4_s;
  logic [15:0] out2_q_s;
  logic [15:0] out4_q_s;

  int passed;
  int total;

  wide_mux_unit #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .in2(in2), .sel2(sel2), .out2(out2),
    .in4(in4), .sel4(sel4), .out4(out4),
    .out2_q(out2_q), .out4_q(out4_q)
  );

  wide_mux_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset),
    .in2(in2_s), .sel2(sel2_s), .out2(out2_s),
    .in4(in4_s), .sel4(sel4_s), .out4(out4_s),
    .out2_q(out2_q_s), .out4_q(out4_q_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    in2 = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    in4 = '{64'h9, 64'hA, 64'hB, 64'hC};
    sel2 = 1'b1;
    sel4 = 2'd3;
    #2;
    total++;
    if (out2_q !== 64'h0) $display("FAIL reset_out2_q: got %h expected %h", out2_q, 64'h0);
    else passed++;
    total++;
    if (out4_q !== 64'h0) $display("FAIL reset_out4_q: got %h expected %h", out4_q, 64'h0);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (out4_q !== 64'h0) $display("FAIL reset_hold_out4_q: got %h expected %h", out4_q, 64'h0);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_mux2_basic();
    in2 = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
    sel2 = 1'b0;
    #1;
    total++;
    if (out2 !== 64'hAAAA_AAAA_AAAA_AAAA)
      $display("FAIL mux2_sel0: got %h expected %h", out2, 64'hAAAA_AAAA_AAAA_AAAA);
    else passed++;
    sel2 = 1'b1;
    #1;
    total++;
    if (out2 !== 64'h5555_5555_5555_5555)
      $display("FAIL mux2_sel1: got %h expected %h", out2, 64'h5555_5555_5555_5555);
    else passed++;
  endtask

  task automatic test_mux4_sweep();
    logic [63:0] exp_v [0:3];
    exp_v = '{64'h1, 64'h2_0000, 64'h3_0000_0000, 64'h4000_0000_0000_0000};
    in4 = '{64'h1, 64'h2_0000, 64'h3_0000_0000, 64'h4000_0000_0000_0000};
    for (int s = 0; s < 4; s++) begin
      sel4 = 2'(s);
      #1;
      total++;
      if (out4 !== exp_v[s]) $display("FAIL mux4_sel%0d: got %h expected %h", s, out4, exp_v[s]);
      else passed++;
    end
  endtask

  task automatic test_move_calc();
    logic [15:0] data16;
    logic [15:0] imm16;
    for (int n = 0; n < 2048; n++) begin
      data16 = 16'($urandom);
      imm16  = 16'($urandom);
      in2_s = '{data16, imm16};
      sel2_s = 1'b1;
      #1;
      total++;
      if (out2_s !== imm16) $display("FAIL move_imm[%0d]: got %h expected %h", n, out2_s, imm16);
      else passed++;
      sel2_s = 1'b0;
      #1;
      total++;
      if (out2_s !== data16) $display("FAIL move_data[%0d]: got %h expected %h", n, out2_s, data16);
      else passed++;
    end
  endtask

  task automatic test_registered();
    @(posedge clk); #1;
    in4 = '{64'h0000_0000_0000_0011, 64'h22, 64'hDEAD_BEEF_0123_4567, 64'h44};
    in2 = '{64'h0123_0123_0123_0123, 64'hFEDC_BA98_7654_3210};
    sel4 = 2'd0;
    sel2 = 1'b0;
    @(posedge clk); #1;
    total++;
    if (out4_q !== 64'h11) $display("FAIL reg_preload_out4_q: got %h expected %h", out4_q, 64'h11);
    else passed++;
    sel4 = 2'd2;
    sel2 = 1'b1;
    #3;
    total++;
    if (out4_q !== 64'h11) $display("FAIL reg_early_out4_q: got %h expected %h", out4_q, 64'h11);
    else passed++;
    total++;
    if (out2_q !== 64'h0123_0123_0123_0123)
      $display("FAIL reg_early_out2_q: got %h expected %h", out2_q, 64'h0123_0123_0123_0123);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (out4_q !== 64'hDEAD_BEEF_0123_4567)
      $display("FAIL reg_out4_q: got %h expected %h", out4_q, 64'hDEAD_BEEF_0123_4567);
    else passed++;
    total++;
    if (out2_q !== 64'hFEDC_BA98_7654_3210)
      $display("FAIL reg_out2_q: got %h expected %h", out2_q, 64'hFEDC_BA98_7654_3210);
    else passed++;
  endtask

  task automatic test_async_reset();
    #3;
    reset = 1'b1;
    #1;
    total++;
    if (out4_q !== 64'h0) $display("FAIL async_out4_q: got %h expected %h", out4_q, 64'h0);
    else passed++;
    total++;
    if (out2_q !== 64'h0) $display("FAIL async_out2_q: got %h expected %h", out2_q, 64'h0);
    else passed++;
    total++;
    if (out4 !== 64'hDEAD_BEEF_0123_4567)
      $display("FAIL async_comb_out4: got %h expected %h", out4, 64'hDEAD_BEEF_0123_4567);
    else passed++;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      total++;
      if (out4_q !== 64'h0 || out2_q !== 64'h0)
        $display("FAIL async_hold_edge%0d: got %h/%h expected 0/0", e, out4_q, out2_q);
      else passed++;
    end
    sel4 = 2'd3;
    reset = 1'b0;
    #2;
    total++;
    if (out4_q !== 64'h0) $display("FAIL release_pre_edge: got %h expected %h", out4_q, 64'h0);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (out4_q !== 64'h44) $display("FAIL release_out4_q: got %h expected %h", out4_q, 64'h44);
    else passed++;
    total++;
    if (out2_q !== 64'hFEDC_BA98_7654_3210)
      $display("FAIL release_out2_q: got %h expected %h", out2_q, 64'hFEDC_BA98_7654_3210);
    else passed++;
  endtask

  task automatic test_bit_independence();
    logic [63:0] expv;
    int j;
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 4; k++) in4[k] = {$urandom, $urandom};
      in2[0] = {$urandom, $urandom};
      in2[1] = {$urandom, $urandom};
      for (int s = 0; s < 4; s++) begin
        sel4 = 2'(s);
        sel2 = s[0];
        #1;
        expv = in4[s];
        total++;
        if (out4 !== expv) $display("FAIL bits_out4[%0d,%0d]: got %h expected %h", n, s, out4, expv);
        else passed++;
        total++;
        if (out2 !== in2[s % 2]) $display("FAIL bits_out2[%0d,%0d]: got %h expected %h", n, s, out2, in2[s % 2]);
        else passed++;
        j = (s + 1 + n % 3) % 4;
        in4[j] = ~in4[j];
        in2[1 - (s % 2)] = ~in2[1 - (s % 2)];
        #1;
        total++;
        if (out4 !== expv) $display("FAIL toggle_out4[%0d,%0d]: got %h expected %h", n, s, out4, expv);
        else passed++;
        total++;
        if (out2 !== in2[s % 2]) $display("FAIL toggle_out2[%0d,%0d]: got %h expected %h", n, s, out2, in2[s % 2]);
        else passed++;
      end
    end
  endtask

  initial begin
    passed = 0;
    total = 0;
    in2_s = '{16'h0, 16'h0};
    in4_s = '{16'h0, 16'h0, 16'h0, 16'h0};
    sel2_s = 1'b0;
    sel4_s = 2'd0;
    test_reset();
    test_mux2_basic();
    test_mux4_sweep();
    test_move_calc();
    test_registered();
    test_async_reset();
    test_bit_independence();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
